// File: rtl/loader_pkg.sv
// Shared state encoding and handshake bytes for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN   = 3'd0,
        INSTR = 3'd1,
        IMM   = 3'd2,
        SUM   = 3'd3,
        ACK   = 3'd4,
        ERR   = 3'd5,
        RUN   = 3'd6
    } state_t;

    localparam logic [7:0] ACK_OK  = 8'hAA;
    localparam logic [7:0] ACK_ERR = 8'hEE;

endpackage

// File: rtl/program_loader.sv
// Fills instruction/immediate ROMs from UART words, verifies an XOR checksum,
// acknowledges the host and then releases the core and hands over the UART.
import loader_pkg::*;

module program_loader #(
    parameter int ROM_SIZE_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      recv_ready,
    input  logic [31:0]               recv_data,
    output logic                      recv_enable,
    input  logic                      send_ready,
    output logic                      send_enable,
    output logic [7:0]                send_data,
    output logic                      imem_we,
    output logic                      immm_we,
    output logic [ROM_SIZE_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      core_rst,
    output logic                      loader_active
);

    localparam logic [31:0] MAX_LEN = 32'd1 << ROM_SIZE_WIDTH;
    localparam logic [ROM_SIZE_WIDTH:0] IDX_ONE = {{ROM_SIZE_WIDTH{1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic [31:0]               count_q, count_d;
    logic [31:0]               sum_q, sum_d;
    logic [ROM_SIZE_WIDTH:0]   idx_q, idx_d;
    logic                      pop_q;
    logic                      imem_we_q, imem_we_d;
    logic                      immm_we_q, immm_we_d;
    logic [ROM_SIZE_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic                      rx_state;
    logic                      last_pair;

    // pop_q blocks a second pop on the cycle right after one, so the
    // receiver always has an edge to present its next head word.
    assign rx_state    = (state_q == LEN) || (state_q == INSTR) ||
                         (state_q == IMM) || (state_q == SUM);
    assign recv_enable = rx_state && recv_ready && !pop_q;

    // idx is one bit wider than the address so a full-size image ends cleanly.
    assign last_pair = ({{(31-ROM_SIZE_WIDTH){1'b0}}, idx_q} == (count_q - 32'd1));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        imem_we_d   = 1'b0;
        immm_we_d   = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        send_enable = 1'b0;
        send_data   = 8'h00;
        case (state_q)
            LEN: if (recv_enable) begin
                count_d = recv_data;
                idx_d   = '0;
                sum_d   = '0;
                if (recv_data > MAX_LEN)    state_d = ERR;
                else if (recv_data == 32'd0) state_d = SUM;
                else                         state_d = INSTR;
            end
            INSTR: if (recv_enable) begin
                imem_we_d = 1'b1;
                addr_d    = idx_q[ROM_SIZE_WIDTH-1:0];
                wdata_d   = recv_data;
                sum_d     = sum_q ^ recv_data;
                state_d   = IMM;
            end
            IMM: if (recv_enable) begin
                immm_we_d = 1'b1;
                addr_d    = idx_q[ROM_SIZE_WIDTH-1:0];
                wdata_d   = recv_data;
                sum_d     = sum_q ^ recv_data;
                if (last_pair) begin
                    state_d = SUM;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = INSTR;
                end
            end
            SUM: if (recv_enable) begin
                state_d = (recv_data == sum_q) ? ACK : ERR;
            end
            ACK: if (send_ready) begin
                send_enable = 1'b1;
                send_data   = ACK_OK;
                state_d     = RUN;
            end
            ERR: if (send_ready) begin
                send_enable = 1'b1;
                send_data   = ACK_ERR;
                state_d     = LEN;
            end
            RUN:     state_d = RUN;
            default: state_d = LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LEN;
            count_q   <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            pop_q     <= 1'b0;
            imem_we_q <= 1'b0;
            immm_we_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            pop_q     <= recv_enable;
            imem_we_q <= imem_we_d;
            immm_we_q <= immm_we_d;
            addr_q    <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    assign imem_we       = imem_we_q;
    assign immm_we       = immm_we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign core_rst      = (state_q != RUN);
    assign loader_active = (state_q != RUN);

endmodule
